// File: rtl/spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// spike_aer_encoder
//
// Samples the spike outputs of a bank of neurons every cycle and serialises
// each spike into an address-event word (neuron index, plus an optional
// timestamp). Coincident spikes are scanned out lowest index first through a
// small show-ahead FIFO to a valid/ready port. Spikes that cannot be queued
// are counted in a saturating drop counter.
//
// Two spike masks are kept:
//   active : the batch currently being scanned into the FIFO
//   shadow : the next batch, accumulated while active is still scanning
//
// Optional feature macro: SPIKE_AER_TS_EN
//   defined   -> free-running timestamp counter, per-mask timestamps, out_ts
//                port, FIFO word = {addr, ts}
//   undefined -> no timestamp logic, FIFO word = addr
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   spike_in   in   N_NEURONS  one spike bit per neuron, sampled every cycle
//   out_valid  out  1          event word valid
//   out_ready  in   1          consumer accepts the word
//   out_addr   out  AW         index of the neuron that spiked
//   out_ts     out  TS_WIDTH   spike timestamp (SPIKE_AER_TS_EN only)
//   drop_cnt   out  8          saturating count of lost spikes
//   busy       out  1          masks or FIFO hold pending work
// ---------------------------------------------------------------------------
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int AW         = $clog2(N_NEURONS),
    parameter int TS_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        out_addr,
`ifdef SPIKE_AER_TS_EN
    output logic [TS_WIDTH-1:0]  out_ts,
`endif
    output logic [7:0]           drop_cnt,
    output logic                 busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
`ifdef SPIKE_AER_TS_EN
    localparam int WW = AW + TS_WIDTH;
`else
    localparam int WW = AW;
`endif

    // Reject configurations outside the supported range at elaboration.
    if ((N_NEURONS < 2) || (N_NEURONS > 32) || (TS_WIDTH < 1) ||
        (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
        $error("spike_aer_encoder: unsupported parameter combination");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [AW-1:0] lowest_index(input logic [N_NEURONS-1:0] mask);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            idx = mask[i] ? AW'(i) : idx;
        end
        return idx;
    endfunction

    // Number of set bits (N_NEURONS <= 32, so 6 bits suffice).
    function automatic logic [5:0] popcount(input logic [N_NEURONS-1:0] mask);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < N_NEURONS; i++) begin
            cnt = cnt + 6'(mask[i]);
        end
        return cnt;
    endfunction

    state_t                 state_q, state_d;
    logic [N_NEURONS-1:0]   active_q, active_d;
    logic [N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   busy_q, busy_d;

    logic [WW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   fifo_full_s;
    logic                   pop_s;
    logic                   push_s;
    logic [AW-1:0]          scan_addr_s;
    logic [N_NEURONS-1:0]   active_rem_s;
    logic [N_NEURONS-1:0]   drop_mask_s;
    logic [8:0]             drop_sum_s;
    logic [WW-1:0]          push_word_s;

    // FIFO status and the scan write: a full FIFO still takes a word when
    // the head is popped on the same edge.
    always_comb begin
        fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
        pop_s        = (count_q != '0) & out_ready;
        push_s       = (state_q == ST_SCAN) & (~fifo_full_s | pop_s);
        scan_addr_s  = lowest_index(active_q);
        // x & (x-1) clears the lowest set bit, i.e. the one being written.
        active_rem_s = push_s ? (active_q & (active_q - N_NEURONS'(1))) : active_q;
    end

`ifdef SPIKE_AER_TS_EN
    logic [TS_WIDTH-1:0]    ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0]    active_ts_q, active_ts_d;
    logic [TS_WIDTH-1:0]    shadow_ts_q, shadow_ts_d;
    logic                   load_spike_s;
    logic                   handover_s;
    logic                   shadow_first_s;

    assign load_spike_s   = (active_rem_s == '0) & (shadow_q == '0);
    assign handover_s     = (active_rem_s == '0) & (shadow_q != '0);
    assign shadow_first_s = (active_rem_s != '0) & (shadow_q == '0);
    assign push_word_s    = {scan_addr_s, active_ts_q};

    // Timestamp bookkeeping that follows the mask moves below; a shadow
    // keeps the timestamp of its first spike across later merges.
    always_comb begin
        ts_cnt_d    = ts_cnt_q + TS_WIDTH'(1);
        active_ts_d = active_ts_q;
        shadow_ts_d = shadow_ts_q;
        if (load_spike_s) begin
            active_ts_d = ts_cnt_q;
        end else if (handover_s) begin
            active_ts_d = shadow_ts_q;
            shadow_ts_d = ts_cnt_q;
        end else if (shadow_first_s) begin
            shadow_ts_d = ts_cnt_q;
        end else begin
            shadow_ts_d = shadow_ts_q;
        end
    end

    // Timestamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt_q    <= '0;
            active_ts_q <= '0;
            shadow_ts_q <= '0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            active_ts_q <= active_ts_d;
            shadow_ts_q <= shadow_ts_d;
        end
    end
`else
    assign push_word_s = scan_addr_s;
`endif

    // Mask update: load, handover or merge, plus drop detection. A merge
    // into a non-empty shadow loses any bit already pending in either mask.
    always_comb begin
        active_d    = active_rem_s;
        shadow_d    = shadow_q;
        drop_mask_s = '0;
        if (active_rem_s == '0) begin
            if (shadow_q == '0) begin
                active_d = spike_in;
            end else begin
                active_d = shadow_q;
                shadow_d = spike_in;
            end
        end else begin
            if (shadow_q == '0) begin
                shadow_d = spike_in;
            end else begin
                drop_mask_s = spike_in & (shadow_q | active_rem_s);
                shadow_d    = shadow_q | (spike_in & ~drop_mask_s);
            end
        end
    end

    // Saturating drop counter; at most 32 drops per edge, so 9 bits of sum
    // are enough to detect overflow.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_q} + {3'b000, popcount(drop_mask_s)};
        if (drop_sum_s[8]) begin
            drop_cnt_d = 8'hFF;
        end else begin
            drop_cnt_d = drop_sum_s[7:0];
        end
    end

    // Scan state machine next state: scanning whenever active holds bits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (active_d != '0) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (active_d == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (active_d != '0) | (shadow_d != '0) | (count_d != '0);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            active_q   <= '0;
            shadow_q   <= '0;
            drop_cnt_q <= 8'h00;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the show-ahead head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_addr  = mem_q[rd_ptr_q][WW-1 -: AW];
`ifdef SPIKE_AER_TS_EN
    assign out_ts    = mem_q[rd_ptr_q][TS_WIDTH-1:0];
`endif
    assign drop_cnt  = drop_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int TSW   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] spike_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_addr;
    logic [7:0] drop_cnt;
    logic       busy;
`ifdef SPIKE_AER_TS_EN
    logic [7:0] out_ts;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: pending indices as a sorted queue, shadow as a set,
    // FIFO as a queue of words.
    typedef struct packed {
        logic [2:0] a;
        logic [7:0] t;
    } word_t;

    word_t      m_fifo[$];
    int         m_act[$];
    int         m_act_ts;
    logic [7:0] m_sh;
    int         m_sh_ts;
    int         m_ts;
    int         m_drop;
    bit         m_busy;

    int log_a[$];
`ifdef SPIKE_AER_TS_EN
    int log_t[$];
`endif

    spike_aer_encoder #(
        .N_NEURONS (N),
        .TS_WIDTH  (TSW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spike_in (spike_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
`ifdef SPIKE_AER_TS_EN
        .out_ts   (out_ts),
`endif
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic bit in_act(input int idx);
        foreach (m_act[k]) if (m_act[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_act.delete();
        m_act_ts = 0;
        m_sh     = 8'h00;
        m_sh_ts  = 0;
        m_ts     = 0;
        m_drop   = 0;
        m_busy   = 1'b0;
        log_a.delete();
`ifdef SPIKE_AER_TS_EN
        log_t.delete();
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        spike_in  = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs, log any accepted DUT word, advance the model,
    // and return at the following falling edge.
    task automatic step(input logic [7:0] sp, input logic rdy);
        bit    pop;
        bit    push;
        int    drops;
        word_t w;
        spike_in  = sp;
        out_ready = rdy;
        if (out_valid && out_ready) begin
            log_a.push_back(int'(out_addr));
`ifdef SPIKE_AER_TS_EN
            log_t.push_back(int'(out_ts));
`endif
        end
        pop  = (m_fifo.size() > 0) && rdy;
        push = (m_act.size() > 0) && ((m_fifo.size() < DEPTH) || pop);
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            w.a = 3'(m_act.pop_front());
            w.t = 8'(m_act_ts);
            m_fifo.push_back(w);
        end
        drops = 0;
        if (m_act.size() == 0) begin
            if (m_sh == 8'h00) begin
                for (int i = 0; i < N; i++) if (sp[i]) m_act.push_back(i);
                m_act_ts = m_ts;
            end else begin
                for (int i = 0; i < N; i++) if (m_sh[i]) m_act.push_back(i);
                m_act_ts = m_sh_ts;
                m_sh     = sp;
                m_sh_ts  = m_ts;
            end
        end else if (m_sh == 8'h00) begin
            m_sh    = sp;
            m_sh_ts = m_ts;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sp[i]) begin
                    if (m_sh[i] || in_act(i)) drops++;
                    else m_sh[i] = 1'b1;
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        m_ts   = (m_ts + 1) % 256;
        m_busy = (m_act.size() > 0) || (m_sh != 8'h00) || (m_fifo.size() > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else checks_passed++;
        checks_total++; if (out_addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", out_addr); else checks_passed++;
        checks_total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else checks_passed++;
`ifdef SPIKE_AER_TS_EN
        checks_total++; if (out_ts !== 8'd0) $display("FAIL reset_ts: got %0d want 0", out_ts); else checks_passed++;
`endif
    endtask

    task automatic test_single_spike();
        do_reset();
        repeat (5) step(8'h00, 1'b1);
        step(8'h10, 1'b1);
        checks_total++; if (out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", out_valid); else checks_passed++;
        checks_total++; if (busy !== 1'b1) $display("FAIL single_busy1: got %b want 1", busy); else checks_passed++;
        step(8'h00, 1'b1);
        checks_total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else checks_passed++;
        checks_total++; if (out_addr !== 3'd4) $display("FAIL single_addr: got %0d want 4", out_addr); else checks_passed++;
`ifdef SPIKE_AER_TS_EN
        checks_total++; if (out_ts !== 8'd5) $display("FAIL single_ts: got %0d want 5", out_ts); else checks_passed++;
`endif
        step(8'h00, 1'b1);
        checks_total++; if (out_valid !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", out_valid); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL single_busy0: got %b want 0", busy); else checks_passed++;
        checks_total++; if (log_a.size() != 1) $display("FAIL single_count: got %0d want 1", log_a.size()); else checks_passed++;
    endtask

    task automatic test_coincident();
        int exp_a[4] = '{0, 2, 5, 7};
        do_reset();
        repeat (3) step(8'h00, 1'b1);
        step(8'hA5, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step(8'h00, 1'b1);
            checks_total++;
            if (out_valid !== 1'b1 || int'(out_addr) != exp_a[j])
                $display("FAIL coinc_word%0d: got valid=%b addr=%0d want valid=1 addr=%0d", j, out_valid, out_addr, exp_a[j]);
            else checks_passed++;
`ifdef SPIKE_AER_TS_EN
            checks_total++; if (out_ts !== 8'd3) $display("FAIL coinc_ts%0d: got %0d want 3", j, out_ts); else checks_passed++;
`endif
        end
        step(8'h00, 1'b1);
        checks_total++; if (out_valid !== 1'b0) $display("FAIL coinc_end: got %b want 0", out_valid); else checks_passed++;
    endtask

    task automatic test_backpressure();
        int guard;
        do_reset();
        step(8'hFF, 1'b0);
        for (int j = 0; j < 6; j++) begin
            step(8'h00, 1'b0);
            checks_total++;
            if (out_valid !== 1'b1 || out_addr !== 3'd0)
                $display("FAIL bp_hold%0d: got valid=%b addr=%0d want valid=1 addr=0", j, out_valid, out_addr);
            else checks_passed++;
        end
        checks_total++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else checks_passed++;
        guard = 0;
        while (log_a.size() < 8 && guard < 20) begin
            step(8'h00, 1'b1);
            guard++;
        end
        checks_total++; if (log_a.size() != 8) $display("FAIL bp_count: got %0d want 8", log_a.size()); else checks_passed++;
        for (int j = 0; j < log_a.size() && j < 8; j++) begin
            checks_total++; if (log_a[j] != j) $display("FAIL bp_order%0d: got %0d want %0d", j, log_a[j], j); else checks_passed++;
        end
        checks_total++; if (drop_cnt !== 8'd0) $display("FAIL bp_drop: got %0d want 0", drop_cnt); else checks_passed++;
    endtask

    task automatic test_shadow_drop();
        int exp_a[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        int guard;
        do_reset();
        repeat (9) step(8'h00, 1'b0);
        step(8'hFF, 1'b0);
        step(8'h01, 1'b0);
        step(8'h03, 1'b0);
        checks_total++; if (drop_cnt !== 8'd1) $display("FAIL sh_drop: got %0d want 1", drop_cnt); else checks_passed++;
        guard = 0;
        while (log_a.size() < 10 && guard < 40) begin
            step(8'h00, 1'b1);
            guard++;
        end
        checks_total++; if (log_a.size() != 10) $display("FAIL sh_count: got %0d want 10", log_a.size()); else checks_passed++;
        for (int j = 0; j < log_a.size() && j < 10; j++) begin
            checks_total++; if (log_a[j] != exp_a[j]) $display("FAIL sh_order%0d: got %0d want %0d", j, log_a[j], exp_a[j]); else checks_passed++;
`ifdef SPIKE_AER_TS_EN
            checks_total++; if (log_t[j] != ((j < 8) ? 9 : 10)) $display("FAIL sh_ts%0d: got %0d want %0d", j, log_t[j], (j < 8) ? 9 : 10); else checks_passed++;
`endif
        end
        checks_total++; if (busy !== 1'b0) $display("FAIL sh_busy: got %b want 0", busy); else checks_passed++;
        checks_total++; if (drop_cnt !== 8'd1) $display("FAIL sh_drop_hold: got %0d want 1", drop_cnt); else checks_passed++;
    endtask

    task automatic test_ts_wrap();
        int guard;
        do_reset();
        repeat (255) step(8'h00, 1'b1);
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        guard = 0;
        while (log_a.size() < 2 && guard < 10) begin
            step(8'h00, 1'b1);
            guard++;
        end
        checks_total++;
        if (log_a.size() != 2 || log_a[0] != 0 || log_a[1] != 1)
            $display("FAIL wrap_addr: got %0d words want addrs 0,1", log_a.size());
        else checks_passed++;
`ifdef SPIKE_AER_TS_EN
        checks_total++;
        if (log_t.size() != 2 || log_t[0] != 255 || log_t[1] != 0)
            $display("FAIL wrap_ts: got %0d words want ts 255,0", log_t.size());
        else checks_passed++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'hFF, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid); else checks_passed++;
        checks_total++; if (drop_cnt !== 8'd0) $display("FAIL arst_drop: got %0d want 0", drop_cnt); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else checks_passed++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (12) step(8'h00, 1'b1);
        checks_total++; if (log_a.size() != 0) $display("FAIL arst_stale: got %0d words want 0", log_a.size()); else checks_passed++;
        checks_total++; if (out_valid !== 1'b0) $display("FAIL arst_after: got %b want 0", out_valid); else checks_passed++;
    endtask

    task automatic test_random();
        logic [7:0] sp;
        logic       rdy;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            if (c < 300) begin
                sp  = ($urandom_range(0, 3) != 0) ? 8'($urandom) : 8'h00;
                rdy = ($urandom_range(0, 7) == 0);
            end else begin
                sp  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                rdy = ($urandom_range(0, 3) != 0);
            end
            step(sp, rdy);
            checks_total++;
            if (out_valid !== (m_fifo.size() > 0)) $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, m_fifo.size() > 0);
            else checks_passed++;
            if (m_fifo.size() > 0) begin
                checks_total++;
                if (out_addr !== m_fifo[0].a) $display("FAIL rnd_addr c=%0d: got %0d want %0d", c, out_addr, m_fifo[0].a);
                else checks_passed++;
`ifdef SPIKE_AER_TS_EN
                checks_total++;
                if (out_ts !== m_fifo[0].t) $display("FAIL rnd_ts c=%0d: got %0d want %0d", c, out_ts, m_fifo[0].t);
                else checks_passed++;
`endif
            end
            checks_total++;
            if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop c=%0d: got %0d want %0d", c, drop_cnt, m_drop);
            else checks_passed++;
            checks_total++;
            if (busy !== m_busy) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_busy);
            else checks_passed++;
            if (c == 299) begin
                checks_total++;
                if (drop_cnt !== 8'hFF) $display("FAIL rnd_saturate: got %0d want 255", drop_cnt);
                else checks_passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_coincident();
        test_backpressure();
        test_shadow_drop();
        test_ts_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
